// File: rtl/cw_beam_sched.sv
// Per-slot sequencer: codeword table preload, symbol indexing and per-stream RE/RBG counting.
// Optional macro CW_SCHED_TIMEOUT_EN adds a WAIT_TBL timeout with preload retry.
module cw_beam_sched #(
   parameter int RE_PER_RBG    = 48,
   parameter int SYMB_PER_SLOT = 14,
   parameter int FIRST_SYMBS   = 4
`ifdef CW_SCHED_TIMEOUT_EN
   ,parameter int TBL_TIMEOUT  = 255
`endif
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_rbg_total,
   input  logic       i_rvalid,
   input  logic       i_sop,
   input  logic       i_eop,
   input  logic       i_tvalid,
   output logic       o_enable,
   output logic [7:0] o_symb_idx,
   output logic       o_symb_clr,
   output logic       o_symb_1st,
   output logic [7:0] o_re_num,
   output logic [7:0] o_rbg_num,
   output logic       o_rbg_load,
   output logic       o_busy,
   output logic [3:0] o_err
);

   localparam logic [7:0] RE_LAST   = 8'(RE_PER_RBG - 1);
   localparam logic [7:0] RE_PEN    = 8'(RE_PER_RBG - 2);
   localparam logic [7:0] SYMB_LAST = 8'(SYMB_PER_SLOT - 1);
   localparam logic [7:0] FIRST_LIM = 8'(FIRST_SYMBS);

   typedef enum logic [2:0] {
      S_LOAD,
      S_WAIT_TBL,
      S_IDLE,
      S_WAIT_SOP,
      S_RUN
   } state_t;

   state_t     r_state;
   logic [6:0] r_ld_cnt;
   logic [7:0] r_rbg_total;
   logic [7:0] r_re_cnt;
   logic [7:0] r_rbg_cnt;
`ifdef CW_SCHED_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TBL_TIMEOUT - 1);
   logic [15:0] r_to_cnt;
`endif

   // A beat is consumed in RUN, or in WAIT_SOP only when it opens a symbol.
   logic       w_beat;
   logic [7:0] w_re_idx;
   logic [7:0] w_rbg_idx;
   logic       w_re_wrap;
   logic       w_last_rbg;
   logic [7:0] w_symb_next;

   assign w_beat      = i_rvalid & ((r_state == S_RUN) | ((r_state == S_WAIT_SOP) & i_sop));
   assign w_re_idx    = i_sop ? 8'd0 : r_re_cnt;
   assign w_rbg_idx   = i_sop ? 8'd0 : r_rbg_cnt;
   assign w_re_wrap   = (w_re_idx == RE_LAST);
   assign w_last_rbg  = (w_rbg_idx == (r_rbg_total - 8'd1));
   assign w_symb_next = o_symb_idx + 8'd1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_LOAD;
         r_ld_cnt    <= '0;
         r_rbg_total <= '0;
         r_re_cnt    <= '0;
         r_rbg_cnt   <= '0;
`ifdef CW_SCHED_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
         o_enable    <= 1'b0;
         o_symb_idx  <= '0;
         o_symb_clr  <= 1'b0;
         o_symb_1st  <= 1'b1;
         o_re_num    <= '0;
         o_rbg_num   <= '0;
         o_rbg_load  <= 1'b0;
         o_busy      <= 1'b1;
         o_err       <= '0;
      end else begin
         o_symb_clr <= 1'b0;
         o_rbg_load <= 1'b0;
         if (i_start && (r_state != S_IDLE))
            o_err[0] <= 1'b1;

         case (r_state)
            S_LOAD: begin
               // 64-cycle address sweep; enable drops on the 65th edge.
               if (r_ld_cnt == 7'd64) begin
                  o_enable <= 1'b0;
                  r_ld_cnt <= '0;
                  r_state  <= S_WAIT_TBL;
               end else begin
                  o_enable <= 1'b1;
                  r_ld_cnt <= r_ld_cnt + 7'd1;
               end
`ifdef CW_SCHED_TIMEOUT_EN
               r_to_cnt <= '0;
`endif
            end
            S_WAIT_TBL: begin
               if (i_tvalid) begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end
`ifdef CW_SCHED_TIMEOUT_EN
               else if (r_to_cnt == TO_LAST) begin
                  o_err[3] <= 1'b1;
                  r_to_cnt <= '0;
                  r_state  <= S_LOAD;
               end else begin
                  r_to_cnt <= r_to_cnt + 16'd1;
               end
`endif
            end
            S_IDLE: begin
               if (i_start) begin
                  r_rbg_total <= i_rbg_total;
                  if (i_rbg_total == 8'd0) begin
                     o_err[3] <= 1'b1;
                  end else begin
                     o_symb_clr <= 1'b1;
                     o_symb_idx <= '0;
                     o_symb_1st <= 1'b1;
                     r_re_cnt   <= '0;
                     r_rbg_cnt  <= '0;
                     o_re_num   <= '0;
                     o_rbg_num  <= '0;
                     o_busy     <= 1'b1;
                     r_state    <= S_WAIT_SOP;
                  end
               end
            end
            S_WAIT_SOP, S_RUN: begin
               if (i_rvalid && (i_sop == (r_state == S_RUN)))
                  o_err[1] <= 1'b1;
               if (w_beat) begin
                  o_re_num  <= w_re_idx;
                  o_rbg_num <= w_rbg_idx;
                  if ((w_re_idx == RE_PEN) && !w_last_rbg)
                     o_rbg_load <= 1'b1;
                  if (i_eop) begin
                     if (!(w_last_rbg && w_re_wrap))
                        o_err[2] <= 1'b1;
                     r_re_cnt  <= '0;
                     r_rbg_cnt <= '0;
                     if (o_symb_idx == SYMB_LAST) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                     end else begin
                        o_symb_idx <= w_symb_next;
                        o_symb_1st <= (w_symb_next < FIRST_LIM);
                        r_state    <= S_WAIT_SOP;
                     end
                  end else begin
                     if (w_re_wrap) begin
                        r_re_cnt  <= '0;
                        r_rbg_cnt <= w_rbg_idx + 8'd1;
                     end else begin
                        r_re_cnt  <= w_re_idx + 8'd1;
                        r_rbg_cnt <= w_rbg_idx;
                     end
                     r_state <= S_RUN;
                  end
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_cw_beam_sched.sv
// Directed bench for cw_beam_sched: preload, full slots, framing errors, illegal starts and reset.
module tb_cw_beam_sched;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_start = 1'b0;
   logic [7:0] i_rbg_total = 8'd0;
   logic       i_rvalid = 1'b0;
   logic       i_sop = 1'b0;
   logic       i_eop = 1'b0;
   logic       i_tvalid = 1'b0;
   logic       o_enable;
   logic [7:0] o_symb_idx;
   logic       o_symb_clr;
   logic       o_symb_1st;
   logic [7:0] o_re_num;
   logic [7:0] o_rbg_num;
   logic       o_rbg_load;
   logic       o_busy;
   logic [3:0] o_err;

   int n_pass = 0;
   int n_total = 0;

   cw_beam_sched dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_rbg_total (i_rbg_total),
      .i_rvalid    (i_rvalid),
      .i_sop       (i_sop),
      .i_eop       (i_eop),
      .i_tvalid    (i_tvalid),
      .o_enable    (o_enable),
      .o_symb_idx  (o_symb_idx),
      .o_symb_clr  (o_symb_clr),
      .o_symb_1st  (o_symb_1st),
      .o_re_num    (o_re_num),
      .o_rbg_num   (o_rbg_num),
      .o_rbg_load  (o_rbg_load),
      .o_busy      (o_busy),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " enable"},   32'(o_enable),   32'd0);
      chk({tag, " symb_idx"}, 32'(o_symb_idx), 32'd0);
      chk({tag, " symb_clr"}, 32'(o_symb_clr), 32'd0);
      chk({tag, " symb_1st"}, 32'(o_symb_1st), 32'd1);
      chk({tag, " re_num"},   32'(o_re_num),   32'd0);
      chk({tag, " rbg_num"},  32'(o_rbg_num),  32'd0);
      chk({tag, " rbg_load"}, 32'(o_rbg_load), 32'd0);
      chk({tag, " busy"},     32'(o_busy),     32'd1);
      chk({tag, " err"},      32'(o_err),      32'd0);
   endtask

   task automatic start_slot(input int total);
      i_start = 1'b1;
      i_rbg_total = 8'(total);
      tick();
      i_start = 1'b0;
      chk("start clr",      32'(o_symb_clr), 32'd1);
      chk("start symb_idx", 32'(o_symb_idx), 32'd0);
      chk("start symb_1st", 32'(o_symb_1st), 32'd1);
      chk("start busy",     32'(o_busy),     32'd1);
      tick();
      chk("clr single pulse", 32'(o_symb_clr), 32'd0);
   endtask

   // Sends one symbol of nbeats back-to-back beats (48 REs per RBG) and checks every beat.
   task automatic symbol(input int s, input int nbeats, input int total, input int start_at);
      int nxt;
      int n_load;
      n_load = 0;
      for (int b = 0; b < nbeats; b++) begin
         i_rvalid = 1'b1;
         i_sop = (b == 0);
         i_eop = (b == nbeats - 1);
         i_start = (b == start_at);
         tick();
         i_rvalid = 1'b0;
         i_sop = 1'b0;
         i_eop = 1'b0;
         i_start = 1'b0;
         if (o_rbg_load) n_load++;
         chk($sformatf("rbg_load s%0d b%0d", s, b), 32'(o_rbg_load),
             32'(((b % 48) == 46) && ((b / 48) != total - 1)));
         if (b != nbeats - 1) begin
            chk($sformatf("re_num s%0d b%0d", s, b),  32'(o_re_num),  32'(b % 48));
            chk($sformatf("rbg_num s%0d b%0d", s, b), 32'(o_rbg_num), 32'(b / 48));
         end
         if (b == 0) begin
            chk($sformatf("symb_idx s%0d", s), 32'(o_symb_idx), 32'(s));
            chk($sformatf("symb_1st s%0d", s), 32'(o_symb_1st), 32'(s < 4));
         end
      end
      nxt = (s == 13) ? 13 : s + 1;
      chk($sformatf("load count s%0d", s),    32'(n_load),     32'(((nbeats + 1) / 48 < total) ? (nbeats + 1) / 48 : total - 1));
      chk($sformatf("symb_idx after s%0d", s), 32'(o_symb_idx), 32'(nxt));
      chk($sformatf("symb_1st after s%0d", s), 32'(o_symb_1st), 32'(nxt < 4));
      chk($sformatf("busy after s%0d", s),     32'(o_busy),     32'(s != 13));
   endtask

   initial begin
      int n_hi;
      int first_hi;
      int last_hi;

      // Reset and preload sweep
      tick();
      tick();
      chk_reset_vals("reset");
      i_reset = 1'b0;
      n_hi = 0; first_hi = -1; last_hi = -1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (o_enable) begin
            n_hi++;
            if (first_hi < 0) first_hi = k;
            last_hi = k;
         end
      end
      chk("enable cycles", 32'(n_hi), 32'd64);
      chk("enable first",  32'(first_hi), 32'd1);
      chk("enable last",   32'(last_hi), 32'd64);
      chk("busy wait_tbl", 32'(o_busy), 32'd1);
      i_tvalid = 1'b1;
      tick();
      tick();
      chk("busy idle",   32'(o_busy),   32'd0);
      chk("enable idle", 32'(o_enable), 32'd0);

      // Clean slot of 14 symbols, 3 RBGs each
      start_slot(3);
      for (int s = 0; s < 14; s++)
         symbol(s, 144, 3, -1);
      chk("err clean slot", 32'(o_err), 32'd0);

      // Short symbol, start in RUN, beat without sop in WAIT_SOP
      start_slot(3);
      symbol(0, 144, 3, -1);
      symbol(1, 100, 3, -1);
      chk("err short eop", 32'(o_err), 32'h4);
      symbol(2, 144, 3, -1);
      chk("err sticky", 32'(o_err), 32'h4);
      symbol(3, 144, 3, 10);
      chk("err start in run", 32'(o_err), 32'h5);
      i_rvalid = 1'b1;
      tick();
      i_rvalid = 1'b0;
      chk("err no sop",        32'(o_err),      32'h7);
      chk("symb_idx after drop", 32'(o_symb_idx), 32'd4);
      for (int s = 4; s < 14; s++)
         symbol(s, 144, 3, -1);
      chk("err end slot2", 32'(o_err), 32'h7);

      // Illegal zero RBG count
      i_start = 1'b1;
      i_rbg_total = 8'd0;
      tick();
      i_start = 1'b0;
      chk("err rbg zero",  32'(o_err),      32'hF);
      chk("clr rbg zero",  32'(o_symb_clr), 32'd0);
      tick();
      chk("busy rbg zero", 32'(o_busy),     32'd0);

      // Reset in the middle of RUN, then the preload repeats
      start_slot(2);
      for (int b = 0; b < 60; b++) begin
         i_rvalid = 1'b1;
         i_sop = (b == 0);
         tick();
      end
      i_rvalid = 1'b0;
      i_sop = 1'b0;
      chk("mid rbg_num", 32'(o_rbg_num), 32'd1);
      chk("mid re_num",  32'(o_re_num),  32'd11);
      i_tvalid = 1'b0;
      i_reset = 1'b1;
      tick();
      chk_reset_vals("mid reset");
      i_reset = 1'b0;
      tick();
      chk("preload again", 32'(o_enable), 32'd1);

`ifdef CW_SCHED_TIMEOUT_EN
      begin
         int waited;
         waited = 0;
         while (!o_err[3] && waited < 600) begin
            tick();
            waited++;
         end
         chk("timeout err", 32'(o_err), 32'h8);
         n_hi = 0;
         for (int k = 0; k < 100; k++) begin
            tick();
            if (o_enable) n_hi++;
         end
         chk("retry enable cycles", 32'(n_hi), 32'd64);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
